// File: rtl/ysyx_220053_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_220053_pkg
// Shared constants for the register-file write-back arbiter and scoreboard.
//   NR_REG : number of architectural registers (x0 hard-wired zero)
//   AW     : register address width, log2(NR_REG)
//   DW     : data width
//   RR_LSU / RR_EXU : round-robin pointer encodings (preferred requester)
// ---------------------------------------------------------------------------
package ysyx_220053_pkg;

    localparam int NR_REG = 32;
    localparam int AW     = 5;
    localparam int DW     = 64;

    localparam logic RR_LSU = 1'b0;
    localparam logic RR_EXU = 1'b1;

endpackage

// File: rtl/ysyx_220053_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_220053_scoreboard
// Busy vector for destination registers with writes in flight.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   set_en, set_addr         mark a register busy at the clock edge
//   clr_en, clr_addr         mark a register idle at the clock edge
//   rd_addr1..3 / rd_busy1..3 combinational busy lookups
//   busy                     full busy vector
//   busy_cnt                 registered population count of busy
// ---------------------------------------------------------------------------
module ysyx_220053_scoreboard
    import ysyx_220053_pkg::*;
#(
    parameter int NR_REG_P = NR_REG,
    parameter int AW_P     = AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [AW_P-1:0]     set_addr,
    input  logic                clr_en,
    input  logic [AW_P-1:0]     clr_addr,
    input  logic [AW_P-1:0]     rd_addr1,
    input  logic [AW_P-1:0]     rd_addr2,
    input  logic [AW_P-1:0]     rd_addr3,
    output logic                rd_busy1,
    output logic                rd_busy2,
    output logic                rd_busy3,
    output logic [NR_REG_P-1:0] busy,
    output logic [AW_P:0]       busy_cnt
);

    logic [NR_REG_P-1:0] busy_next;

    function automatic logic [AW_P:0] popcount(input logic [NR_REG_P-1:0] v);
        logic [AW_P:0] cnt;
        cnt = '0;
        for (int i = 0; i < NR_REG_P; i++) begin
            cnt = cnt + {{AW_P{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Set and clear of the same register in one edge cannot happen (the
    // register is busy while it is being written back, which blocks issue),
    // so their relative priority is irrelevant. Bit 0 is forced low so x0
    // never stalls anything.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // The count is computed from the next-state vector so it always matches
    // the registered busy vector in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= popcount(busy_next);
        end
    end

    assign rd_busy1 = busy[rd_addr1];
    assign rd_busy2 = busy[rd_addr2];
    assign rd_busy3 = busy[rd_addr3];

endmodule

// File: rtl/ysyx_220053_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_220053_wb_arbiter
// Shares the register file's single write port between the EXU result path
// and the LSU load-return path (round-robin), registers the winning write,
// and stalls issue on RAW/WAW hazards against in-flight destinations.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   issue_valid/ready, issue_rs1/rs2/rd, issue_wen   decode/issue interface
//   ex_valid/ready, ex_rd, ex_data    EXU write-back handshake
//   ld_valid/ready, ld_rd, ld_data    LSU write-back handshake
//   rf_wen, rf_waddr, rf_wdata        registered regfile write port
//   busy_cnt                          number of busy registers
//   wb_err                            sticky: write-back to a non-busy register
// ---------------------------------------------------------------------------
module ysyx_220053_wb_arbiter
    import ysyx_220053_pkg::*;
#(
    parameter int NR_REG_P = NR_REG,
    parameter int AW_P     = AW,
    parameter int DW_P     = DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [AW_P-1:0] issue_rs1,
    input  logic [AW_P-1:0] issue_rs2,
    input  logic [AW_P-1:0] issue_rd,
    input  logic            issue_wen,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [AW_P-1:0] ex_rd,
    input  logic [DW_P-1:0] ex_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW_P-1:0] ld_rd,
    input  logic [DW_P-1:0] ld_data,
    output logic            rf_wen,
    output logic [AW_P-1:0] rf_waddr,
    output logic [DW_P-1:0] rf_wdata,
    output logic [AW_P:0]   busy_cnt,
    output logic            wb_err
);

    logic                rs1_busy;
    logic                rs2_busy;
    logic                rd_busy;
    logic [NR_REG_P-1:0] busy;
    logic                issue_fire;
    logic                set_en;
    logic                rr;
    logic                ex_fire;
    logic                ld_fire;
    logic                wb_fire;
    logic [AW_P-1:0]     win_rd;
    logic [DW_P-1:0]     win_data;

    ysyx_220053_scoreboard #(
        .NR_REG_P (NR_REG_P),
        .AW_P     (AW_P)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (issue_rd),
        .clr_en   (rf_wen),
        .clr_addr (rf_waddr),
        .rd_addr1 (issue_rs1),
        .rd_addr2 (issue_rs2),
        .rd_addr3 (issue_rd),
        .rd_busy1 (rs1_busy),
        .rd_busy2 (rs2_busy),
        .rd_busy3 (rd_busy),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Issue stage: hazard check is independent of issue_valid.
    assign issue_ready = !rs1_busy && !rs2_busy && !(issue_wen && rd_busy);
    assign issue_fire  = issue_valid && issue_ready;
    assign set_en      = issue_fire && issue_wen && (issue_rd != '0);

    // Arbitration: the preferred side wins only when both request.
    assign ld_ready = ld_valid && (!ex_valid || rr == RR_LSU);
    assign ex_ready = ex_valid && (!ld_valid || rr == RR_EXU);
    assign ld_fire  = ld_ready;
    assign ex_fire  = ex_ready;
    assign wb_fire  = ld_fire || ex_fire;

    always_comb begin
        win_rd   = ex_rd;
        win_data = ex_data;
        if (ld_fire) begin
            win_rd   = ld_rd;
            win_data = ld_data;
        end
    end

    // Round-robin pointer flips away from the winner on contested cycles only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= RR_LSU;
        end else if (ex_valid && ld_valid) begin
            rr <= ld_fire ? RR_EXU : RR_LSU;
        end
    end

    // Output register stage: rd==0 is accepted but produces no write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (wb_fire) begin
            rf_wen   <= (win_rd != '0);
            rf_waddr <= win_rd;
            rf_wdata <= win_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (wb_fire && (win_rd != '0) && !busy[win_rd]) begin
            wb_err <= 1'b1;
        end
    end

endmodule
